// File: rtl/seq_chunk_addsub.sv
// -----------------------------------------------------------------------------
// seq_chunk_addsub
//   Multi-cycle adder/subtractor. Each clock it adds CHUNK bits of the operands
//   and keeps the carry in a register, so the critical path is one CHUNK-bit
//   adder no matter how wide WIDTH is. A result takes WIDTH/CHUNK clocks.
//   Subtraction is done as A + ~B + ~cin. The operands are prepared once, on
//   the accepting edge, so the datapath itself only ever adds.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b, cin, sub      operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready result handshake (out_valid is high only in DONE)
//   sum, cout, ovf      result (wraps modulo 2^WIDTH), carry-out (for sub,
//                       1 = no borrow), signed overflow
//   busy                high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------
module seq_chunk_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_chunk_addsub: CHUNK must divide WIDTH");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtraction
    logic             carry;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Current slice of the ripple
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_sl;
    logic             c_msb;

    always_comb begin
        a_sl = a_q[int'(idx) * CHUNK +: CHUNK];
        b_sl = b_q[int'(idx) * CHUNK +: CHUNK];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice MSB recovered from the MSB sum bit
        // (s = a ^ b ^ c), which also covers CHUNK=1 where it is just carry.
        c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[int'(idx) * CHUNK +: CHUNK] <= s_sl;
                    carry <= c_sl;
                    if (idx == LAST) begin
                        cout_q <= c_sl;
                        ovf_q  <= c_msb ^ c_sl;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from state so reset clears them at once.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_addsub
//   Scoreboard bench: drivers push the model's expected result when an
//   operation is accepted; monitors pop and compare when a result is handed
//   off. Instance u_dut0 (16/4) gets the directed handshake/reset scenarios;
//   the sw[] blocks run random traffic on 8/8, 8/1 and 32/8.
// -----------------------------------------------------------------------------
module tb_seq_chunk_addsub;

    localparam int PER = 10;

    logic clk = 1'b0;
    always #(PER/2) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        longint      t;     // time of the accepting edge
    } exp_t;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                                  output logic [31:0] s, output logic co, output logic ov);
        longint ua, ub, c, sa, sb, mod, ru, r;
        ua  = longint'(a);
        ub  = longint'(b);
        c   = cin ? 1 : 0;
        mod = longint'(1) << w;
        sa  = (ua >= mod / 2) ? ua - mod : ua;
        sb  = (ub >= mod / 2) ? ub - mod : ub;
        if (!sub) begin
            ru = ua + ub + c;
            co = (ru >= mod);
            r  = sa + sb + c;
        end else begin
            ru = ua - ub - c;
            co = (ua >= ub + c);
            r  = sa - sb - c;
        end
        s  = 32'(ru & (mod - 1));
        ov = (r > mod / 2 - 1) || (r < -(mod / 2));
    endfunction

    // ---------------- directed instance: WIDTH=16, CHUNK=4 ----------------
    localparam int N0 = 4;
    logic        rst0, iv0, ir0, cin0, sub0, ovl0, or0, co0, of0, busy0;
    logic [15:0] a0, b0, s0;
    exp_t        q0[$];
    longint      last_acc;

    seq_chunk_addsub #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst_n(rst0), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(ovl0), .out_ready(or0),
        .sum(s0), .cout(co0), .ovf(of0), .busy(busy0)
    );

    initial begin : mon0
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ovl0 && !prev) begin
                if (q0.size() == 0) chk("spurious_valid_w16", 1, 0);
                else chk("latency_w16", 64'((longint'($time) - PER/2 - q0[0].t) / PER), 64'(N0));
            end
            if (ovl0 && or0 && q0.size() > 0) begin
                e = q0.pop_front();
                chk("result_w16", {32'(s0), co0, of0}, {e.s, e.co, e.ov});
            end
            prev = ovl0;
        end
    end

    task automatic issue0(logic [15:0] a, logic [15:0] b, logic c, logic s, bit push);
        exp_t e;
        bit   ok;
        a0 = a; b0 = b; cin0 = c; sub0 = s; iv0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ir0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout_w16", 0, 1);
            iv0 = 1'b0;
            return;
        end
        @(posedge clk);
        last_acc = longint'($time);
        if (push) begin
            model(16, 32'(a), 32'(b), c, s, e.s, e.co, e.ov);
            e.t = last_acc;
            q0.push_back(e);
        end
        #1 iv0 = 1'b0;
    endtask

    task automatic drain0();
        for (int i = 0; i < 200 && q0.size() > 0; i++) @(posedge clk);
        if (q0.size() > 0) chk("drain_timeout_w16", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- sweep instances ----------------
    logic rst_sw;

    for (genvar g = 1; g < 4; g++) begin : sw
        localparam int W = (g == 3) ? 32 : 8;
        localparam int C = (g == 2) ? 1 : 8;
        localparam int N = W / C;

        logic         iv, ir, cin, sub, ovl, co, of, bsy;
        logic         ordy = 1'b0;
        logic [W-1:0] a, b, s;
        bit           done;
        exp_t         q[$];

        seq_chunk_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst_n(rst_sw), .in_valid(iv), .in_ready(ir),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(ovl), .out_ready(ordy),
            .sum(s), .cout(co), .ovf(of), .busy(bsy)
        );

        // Random back-pressure, also toggling during RUN where it must not matter
        initial forever begin
            @(posedge clk);
            #1 ordy = ($urandom_range(0, 3) != 0);
        end

        initial begin : mon
            bit   prev;
            exp_t e;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (ovl && !prev) begin
                    if (q.size() == 0) chk($sformatf("spurious_valid_w%0d_c%0d", W, C), 1, 0);
                    else chk($sformatf("latency_w%0d_c%0d", W, C),
                             64'((longint'($time) - PER/2 - q[0].t) / PER), 64'(N));
                end
                if (ovl && ordy && q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("result_w%0d_c%0d", W, C), {32'(s), co, of}, {e.s, e.co, e.ov});
                end
                prev = ovl;
            end
        end

        initial begin : drv
            done = 1'b0;
            iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            wait (rst_sw === 1'b1);
            for (int k = 0; k < 40; k++) begin
                exp_t        e;
                bit          ok;
                logic [31:0] ra, rb;
                @(posedge clk);
                #1;
                ra  = $urandom;
                rb  = $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) ra = '1;
                if (k == 0) begin ra = '1; rb = 32'd1; cin = 1'b0; sub = 1'b0; end
                if (k == 1) begin ra = '0; rb = 32'd1; cin = 1'b0; sub = 1'b1; end
                a  = W'(ra);
                b  = W'(rb);
                iv = 1'b1;
                ok = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (ir) begin ok = 1'b1; break; end
                end
                if (!ok) begin
                    chk($sformatf("accept_timeout_w%0d_c%0d", W, C), 0, 1);
                    break;
                end
                @(posedge clk);
                model(W, 32'(a), 32'(b), cin, sub, e.s, e.co, e.ov);
                e.t = longint'($time);
                q.push_back(e);
                #1 iv = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            iv = 1'b0;
            for (int i = 0; i < 1000 && q.size() > 0; i++) @(posedge clk);
            if (q.size() > 0) chk($sformatf("drain_timeout_w%0d_c%0d", W, C), 0, 1);
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        longint t_a;
        bit     seen;
        rst0 = 1'b0; rst_sw = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; or0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {ovl0, ir0, busy0, s0, co0, of0}, {1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        rst0 = 1'b1; rst_sw = 1'b1;
        @(posedge clk);
        #1;

        // Arithmetic vectors, including full ripple and signed overflow
        issue0(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        issue0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue0(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        issue0(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        issue0(16'h0010, 16'h0001, 1'b1, 1'b1, 1'b1);
        drain0();

        // in_valid held high across DONE->IDLE: next op taken on first IDLE edge
        issue0(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1);
        t_a = last_acc;
        issue0(16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b1);
        chk("accept_gap_w16", 64'((last_acc - t_a) / PER), 64'(N0 + 2));
        drain0();

        // in_valid pulse with different operands during RUN is ignored
        issue0(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1; sub0 = 1'b1; iv0 = 1'b1;
        @(posedge clk);
        #1 iv0 = 1'b0;
        drain0();

        // Result held stable in DONE while out_ready is low
        or0 = 1'b0;
        issue0(16'h0AAA, 16'h0555, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ovl0) begin seen = 1'b1; break; end
        end
        if (!seen) chk("done_timeout_w16", 0, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_done", {ovl0, ir0, busy0, s0, co0, of0},
                {1'b1, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 or0 = 1'b1;
        drain0();

        // Reset after two RUN edges: outputs clear before any further clock
        issue0(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst0 = 1'b0;
        #1 chk("async_reset", {ovl0, ir0, busy0, s0, co0, of0},
               {1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        @(negedge clk);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        issue0(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
        drain0();

        // Wait for the sweep instances
        for (int i = 0; i < 20000; i++) begin
            if (sw[1].done && sw[2].done && sw[3].done) break;
            @(posedge clk);
        end
        if (!(sw[1].done && sw[2].done && sw[3].done)) chk("sweep_timeout", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(PER * 60000);
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
